io_uart_in: RTL and testbench

IO_UART_IN -- requirements
Module: io_uart_in

---
 rtl/io_uart_in.sv | 154 +++++++++++++++
 tb/tb_io_uart_in.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_in.sv
// UART receive front end: buffers deserialized bytes in a FIFO and exposes
// DATA / STATUS / CTRL registers on a daisy-chained IO bus.
module io_uart_in #(
    parameter int          DEPTH    = 16,
    parameter logic [13:0] ADR_BASE = 14'h3F04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_rx_char,
    input  logic        uart_rx_we,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        uart_rx_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [13:0]   ADR_DATA   = ADR_BASE;
    localparam logic [13:0]   ADR_STATUS = ADR_BASE + 14'd1;
    localparam logic [13:0]   ADR_CTRL   = ADR_BASE + 14'd2;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovr;
    logic          ien;
    logic          hit_q;
    logic [31:0]   local_q;

    logic          empty;
    logic          full;
    logic          rd_hit;
    logic          rd_data;
    logic          ctrl_we;
    logic          flush;
    logic          clr_ovr;
    logic          pop_en;
    logic          push_en;
    logic          overflow;
    logic [7:0]    head_byte;
    logic [31:0]   status_word;
    logic [31:0]   local_rdata;
    logic          unused_wdata;

    assign unused_wdata = ^dma_io_wdata[31:3];

    // Bus decode; a flush overrides any push or pop landing in the same cycle.
    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_COUNT);
        rd_hit   = dma_io_radr_en && ((dma_io_radr == ADR_DATA) ||
                                      (dma_io_radr == ADR_STATUS) ||
                                      (dma_io_radr == ADR_CTRL));
        rd_data  = dma_io_radr_en && (dma_io_radr == ADR_DATA);
        ctrl_we  = dma_io_we && (dma_io_wadr == ADR_CTRL);
        flush    = ctrl_we && dma_io_wdata[2];
        clr_ovr  = ctrl_we && dma_io_wdata[1];
        pop_en   = rd_data && !empty && !flush;
        push_en  = uart_rx_we && (!full || pop_en) && !flush;
        overflow = uart_rx_we && full && !pop_en && !flush;
    end

    // Register read view, always taken from pre-update state.
    always_comb begin
        head_byte          = empty ? 8'd0 : fifo_mem[rd_ptr];
        status_word        = '0;
        status_word[0]     = !empty;
        status_word[1]     = full;
        status_word[2]     = ovr;
        status_word[3]     = ien;
        status_word[4 +: CW] = count;
        local_rdata        = '0;
        if (dma_io_radr == ADR_DATA) begin
            local_rdata = {24'd0, head_byte};
        end else if (dma_io_radr == ADR_STATUS) begin
            local_rdata = status_word;
        end else if (dma_io_radr == ADR_CTRL) begin
            local_rdata = {31'd0, ien};
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr] <= uart_rx_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_en && !pop_en) begin
                count <= count + CW'(1);
            end else if (pop_en && !push_en) begin
                count <= count - CW'(1);
            end
        end
    end

    // Clearing ovr takes priority over an overflow in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
            ien <= 1'b0;
        end else begin
            if (clr_ovr) begin
                ovr <= 1'b0;
            end else if (overflow) begin
                ovr <= 1'b1;
            end
            if (ctrl_we) begin
                ien <= dma_io_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q       <= 1'b0;
            local_q     <= '0;
            uart_rx_irq <= 1'b0;
        end else begin
            hit_q       <= rd_hit;
            uart_rx_irq <= ien && (!empty || ovr);
            if (rd_hit) begin
                local_q <= local_rdata;
            end
        end
    end

    assign dma_io_rdata = hit_q ? local_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_uart_in.sv
// Directed, table-driven bench for io_uart_in with DEPTH=16, ADR_BASE=14'h3F04.
module tb_io_uart_in;

    localparam logic [13:0] ADR_DATA   = 14'h3F04;
    localparam logic [13:0] ADR_STATUS = 14'h3F05;
    localparam logic [13:0] ADR_CTRL   = 14'h3F06;
    localparam logic [31:0] RI         = 32'hCAFE0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_rx_char;
    logic        uart_rx_we;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        uart_rx_irq;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       name;
        logic        rx_we;
        logic [7:0]  rx_char;
        logic        we;
        logic [13:0] wadr;
        logic [31:0] wdata;
        logic        re;
        logic [13:0] radr;
        logic [31:0] rdata_in;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    io_uart_in #(.DEPTH(16), .ADR_BASE(14'h3F04)) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rx_char   (uart_rx_char),
        .uart_rx_we     (uart_rx_we),
        .dma_io_we      (dma_io_we),
        .dma_io_wadr    (dma_io_wadr),
        .dma_io_wdata   (dma_io_wdata),
        .dma_io_radr    (dma_io_radr),
        .dma_io_radr_en (dma_io_radr_en),
        .dma_io_rdata_in(dma_io_rdata_in),
        .dma_io_rdata   (dma_io_rdata),
        .uart_rx_irq    (uart_rx_irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input string nm, input logic rxw, input logic [7:0] ch,
                                 input logic w, input logic [13:0] wa, input logic [31:0] wd,
                                 input logic r, input logic [13:0] ra, input logic [31:0] ri,
                                 input logic [31:0] er, input logic ei);
        vec_t v;
        v.name = nm; v.rx_we = rxw; v.rx_char = ch; v.we = w; v.wadr = wa; v.wdata = wd;
        v.re = r; v.radr = ra; v.rdata_in = ri; v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    // Drives one cycle of inputs at the falling edge and returns 1ns after the rising edge.
    task automatic applyStimulus(input logic rxw, input logic [7:0] ch, input logic w,
                                 input logic [13:0] wa, input logic [31:0] wd, input logic r,
                                 input logic [13:0] ra, input logic [31:0] ri);
        @(negedge clk);
        uart_rx_we = rxw; uart_rx_char = ch;
        dma_io_we = w; dma_io_wadr = wa; dma_io_wdata = wd;
        dma_io_radr_en = r; dma_io_radr = ra; dma_io_rdata_in = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] exp_rdata, input logic exp_irq);
        n_checks++;
        if (dma_io_rdata !== exp_rdata || uart_rx_irq !== exp_irq) begin
            n_fails++;
            $display("[TB] FAIL %s: rdata=%h irq=%b, expected rdata=%h irq=%b",
                     nm, dma_io_rdata, uart_rx_irq, exp_rdata, exp_irq);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 14'h0, 32'h0, 1'b0, 14'h0, RI);
    endtask

    task automatic pushByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 14'h0, 32'h0, 1'b0, 14'h0, RI);
    endtask

    task automatic writeCtrl(input logic [31:0] wd);
        applyStimulus(1'b0, 8'h00, 1'b1, ADR_CTRL, wd, 1'b0, 14'h0, RI);
    endtask

    task automatic readReg(input string nm, input logic [13:0] ra, input logic [31:0] exp_rdata,
                           input logic exp_irq);
        applyStimulus(1'b0, 8'h00, 1'b0, 14'h0, 32'h0, 1'b1, ra, RI);
        checkOutput(nm, exp_rdata, exp_irq);
    endtask

    initial begin
        rst = 1'b1;
        uart_rx_we = 1'b0; uart_rx_char = '0;
        dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
        dma_io_radr_en = 1'b0; dma_io_radr = '0; dma_io_rdata_in = 32'h13572468;

        vecs.push_back(mkv("idle",         0, 8'h00, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("push41",       1, 8'h41, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("push42",       1, 8'h42, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("rd_data_41",   0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_DATA,   RI,           32'h41,       0));
        vecs.push_back(mkv("rd_data_42",   0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_DATA,   RI,           32'h42,       0));
        vecs.push_back(mkv("rd_status_0",  0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h0,        0));
        vecs.push_back(mkv("rd_empty",     0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_DATA,   RI,           32'h0,        0));
        vecs.push_back(mkv("rd_outside",   0, 8'h00, 0, 14'h0,  32'h0,        1, 14'h3F10,   32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mkv("rd_above",     0, 8'h00, 0, 14'h0,  32'h0,        1, 14'h3F07,   32'h12345678, 32'h12345678, 0));
        vecs.push_back(mkv("rd_below",     0, 8'h00, 0, 14'h0,  32'h0,        1, 14'h3F03,   32'h87654321, 32'h87654321, 0));
        vecs.push_back(mkv("push10",       1, 8'h10, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("push20",       1, 8'h20, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("push30",       1, 8'h30, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("wr_ien",       0, 8'h00, 1, ADR_CTRL, 32'h1,      0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("irq_rise",     0, 8'h00, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           1));
        vecs.push_back(mkv("rd_status_3",  0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h39,       1));
        vecs.push_back(mkv("rd_ctrl_1",    0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_CTRL,   RI,           32'h1,        1));
        vecs.push_back(mkv("wr_flush",     0, 8'h00, 1, ADR_CTRL, 32'h5,      0, 14'h0,      RI,           RI,           1));
        vecs.push_back(mkv("irq_fall",     0, 8'h00, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("rd_status_8",  0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h8,        0));
        vecs.push_back(mkv("wr_data_ign",  0, 8'h00, 1, ADR_DATA,   32'hFFFFFFFF, 0, 14'h0,  RI,           RI,           0));
        vecs.push_back(mkv("wr_stat_ign",  0, 8'h00, 1, ADR_STATUS, 32'hFFFFFFFE, 0, 14'h0,  RI,           RI,           0));
        vecs.push_back(mkv("rd_status_8b", 0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h8,        0));
        vecs.push_back(mkv("rd_wr_same",   0, 8'h00, 1, ADR_CTRL, 32'h0,      1, ADR_STATUS, RI,           32'h8,        0));
        vecs.push_back(mkv("rd_ctrl_0",    0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_CTRL,   RI,           32'h0,        0));
        vecs.push_back(mkv("push_flush",   1, 8'h55, 1, ADR_CTRL, 32'h4,      0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("rd_status_pf", 0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h0,        0));
        vecs.push_back(mkv("push66",       1, 8'h66, 0, 14'h0,  32'h0,        0, 14'h0,      RI,           RI,           0));
        vecs.push_back(mkv("pop_flush",    0, 8'h00, 1, ADR_CTRL, 32'h4,      1, ADR_DATA,   RI,           32'h66,       0));
        vecs.push_back(mkv("rd_status_fl", 0, 8'h00, 0, 14'h0,  32'h0,        1, ADR_STATUS, RI,           32'h0,        0));

        // Reset behaviour: output passes the upstream chain through.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'h13572468, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rx_we, vecs[i].rx_char, vecs[i].we, vecs[i].wadr, vecs[i].wdata,
                          vecs[i].re, vecs[i].radr, vecs[i].rdata_in);
            checkOutput(vecs[i].name, vecs[i].exp_rdata, vecs[i].exp_irq);
        end

        // Overflow: 17 pushes into 16 entries, the last byte is lost.
        for (int i = 1; i <= 17; i++) pushByte(8'(i));
        readReg("ovf_status", ADR_STATUS, 32'h107, 1'b0);
        for (int i = 1; i <= 16; i++) readReg($sformatf("ovf_data_%0d", i), ADR_DATA, 32'(i), 1'b0);
        readReg("ovf_status_drained", ADR_STATUS, 32'h4, 1'b0);
        writeCtrl(32'h2);
        readReg("ovf_cleared", ADR_STATUS, 32'h0, 1'b0);

        // Full FIFO with simultaneous push and pop keeps count at 16 without overflow.
        for (int i = 0; i < 16; i++) pushByte(8'hA0 + 8'(i));
        applyStimulus(1'b1, 8'h77, 1'b0, 14'h0, 32'h0, 1'b1, ADR_DATA, RI);
        checkOutput("full_pushpop_head", 32'hA0, 1'b0);
        readReg("full_pushpop_status", ADR_STATUS, 32'h103, 1'b0);
        for (int i = 1; i < 16; i++) readReg($sformatf("full_drain_%0d", i), ADR_DATA, 32'hA0 + 32'(i), 1'b0);
        readReg("full_drain_new", ADR_DATA, 32'h77, 1'b0);
        readReg("full_drain_status", ADR_STATUS, 32'h0, 1'b0);

        // Clear of ovr wins over a coincident overflow.
        for (int i = 0; i < 16; i++) pushByte(8'(i));
        applyStimulus(1'b1, 8'hEE, 1'b1, ADR_CTRL, 32'h2, 1'b0, 14'h0, RI);
        readReg("clr_vs_ovf_status", ADR_STATUS, 32'h103, 1'b0);
        writeCtrl(32'h4);
        readReg("clr_vs_ovf_flushed", ADR_STATUS, 32'h0, 1'b0);

        // Mid-operation reset with 5 bytes queued, ovr set and irq active.
        for (int i = 0; i < 17; i++) pushByte(8'hC0 + 8'(i));
        for (int i = 0; i < 11; i++) readReg($sformatf("pre_rst_%0d", i), ADR_DATA, 32'hC0 + 32'(i), 1'b0);
        writeCtrl(32'h1);
        idle();
        checkOutput("pre_rst_irq", RI, 1'b1);
        readReg("pre_rst_status", ADR_STATUS, 32'h5D, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        dma_io_radr_en = 1'b1; dma_io_radr = ADR_DATA; dma_io_rdata_in = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        checkOutput("in_rst", 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dma_io_radr_en = 1'b0;
        #1;
        checkOutput("post_rst_passthru", 32'hDEADBEEF, 1'b0);
        readReg("post_rst_status", ADR_STATUS, 32'h0, 1'b0);
        idle();
        checkOutput("post_rst_irq", RI, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
